// File: rtl/exe_muldiv_ctrl.sv
// EXE-stage multi-cycle multiply/divide controller: shift-add multiply, restoring divide, HI/LO results.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module exe_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic               w_fast_mul;
    logic               w_wr_res;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_res;

    // rst gate keeps stall_req low while reset is held even if start is high
    assign w_accept = rst && (r_state == S_IDLE) && start && !flush;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_a_neg  = !op[0] && src_a[WIDTH-1];
    assign w_b_neg  = !op[0] && src_b[WIDTH-1];
    assign w_mag_a  = cond_neg(w_a_neg, src_a);
    assign w_mag_b  = cond_neg(w_b_neg, src_b);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_fast_prod;

    // low 2*WIDTH bits of an unsigned product of extended operands match the signed product
    assign w_ext_a     = op[0] ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign w_ext_b     = op[0] ? {{WIDTH{1'b0}}, src_b} : {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign w_fast_prod = w_ext_a * w_ext_b;
    assign w_fast_mul  = w_accept && !op[1];
`else
    assign w_fast_mul  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_fast_mul ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)       w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign stall_req = w_accept || (r_state == S_CALC);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;

    // Iteration step: multiply keeps {partial, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) w_sum = w_sum + {1'b0, r_opnd};
        w_shifted = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, r_opnd};
        if (!r_is_div)
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        else if (!w_trial[WIDTH])
            w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        else
            w_acc_nxt = {w_shifted[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        if (!r_is_div)
            w_res = cond_neg2(r_neg_res, w_acc_nxt);
        else if (r_div_zero)
            w_res = {r_raw_a, {WIDTH{1'b1}}};
        else
            w_res = {cond_neg(r_neg_rem, w_acc_nxt[2*WIDTH-1:WIDTH]),
                     cond_neg(r_neg_res, w_acc_nxt[WIDTH-1:0])};
`ifdef MULDIV_FAST_MUL_EN
        if (w_fast_mul) w_res = w_fast_prod;
`endif
    end

    assign w_wr_res = ((r_state == S_CALC) && !flush && w_last) || w_fast_mul;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == S_CALC)
                r_cnt <= r_cnt + CW'(1);
            if (w_wr_res)
                {r_hi, r_lo} <= w_res;
        end
    end

    // Operand/datapath registers carry no reset; they are only read while in CALC.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div   <= op[1];
            r_opnd     <= op[1] ? w_mag_b : w_mag_a;
            r_acc      <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= (src_b == '0);
            r_raw_a    <= src_a;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Self-checking bench for exe_muldiv_ctrl: directed vectors plus randomized ops against an arithmetic model.
module tb_exe_muldiv_ctrl;
    localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    exe_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {hi, lo} computed straight from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: r = 64'(sa * sb);
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic scramble();
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Issue one op in the current cycle and follow it cycle by cycle until it is back in IDLE.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp_v;
        logic [31:0] hi0, lo0;
        int          lat;
        bit          hold_ok;
        exp_v   = model(o, a, b);
        lat     = (FAST && !o[1]) ? 1 : WIDTH + 1;
        hi0     = hi;
        lo0     = lo;
        hold_ok = 1'b1;
        start = 1'b1; flush = 1'b0; op = o; src_a = a; src_b = b;
        #1;
        chk({tag, "_accept_stall"}, 64'(stall_req), 64'd1);
        for (int k = 1; k <= lat; k++) begin
            tick();
            scramble();
            start = (k == lat);
            #1;
            if (k < lat && (stall_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || hi !== hi0 || lo !== lo0))
                hold_ok = 1'b0;
        end
        if (lat > 1) chk({tag, "_calc_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, "_done"},       64'(done),      64'd1);
        chk({tag, "_done_stall"}, 64'(stall_req), 64'd0);
        chk({tag, "_hi"},         64'(hi),        64'(exp_v[63:32]));
        chk({tag, "_lo"},         64'(lo),        64'(exp_v[31:0]));
        tick();
        start = 1'b0;
        #1;
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_done"}, 64'(done), 64'd0);
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_const_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_const_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        logic [31:0] hi0, lo0;
        bit          flag;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_hi",    64'(hi),        64'd0);
        chk("rst_lo",    64'(lo),        64'd0);
        #6 rst = 1'b1;
        tick();

        run_op(2'd3, 32'd100, 32'd7, "divu_100_7");
        chk_hilo("divu_100_7", 32'd2, 32'd14);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        chk_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        chk_hilo("div_minneg", 32'd0, 32'h8000_0000);
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
        chk_hilo("mult_m1_2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, "multu_ff_2");
        chk_hilo("multu_ff_2", 32'd1, 32'hFFFF_FFFE);
        run_op(2'd3, 32'd5, 32'd0, "divu_5_0");
        chk_hilo("divu_5_0", 32'd5, 32'hFFFF_FFFF);
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
        chk_hilo("div_m5_0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        chk_hilo("div_7_m2", 32'd1, 32'hFFFF_FFFD);

        // flush in the 10th CALC cycle
        hi0 = hi; lo0 = lo; flag = 1'b0;
        start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd7;
        #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start = 1'b0;
            if (k == 10) flush = 1'b1;
            #1;
            if (done !== 1'b0) flag = 1'b1;
        end
        chk("flush_c10_stall", 64'(stall_req), 64'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_stall_low", 64'(stall_req), 64'd0);
        chk("flush_busy",      64'(busy),      64'd0);
        chk("flush_no_done",   64'(flag | done), 64'd0);
        chk("flush_hi_hold",   64'(hi),        64'(hi0));
        chk("flush_lo_hold",   64'(lo),        64'(lo0));
        run_op(2'd3, 32'd1000, 32'd7, "post_flush");
        chk_hilo("post_flush", 32'd6, 32'd142);

        // flush has priority over start in IDLE
        hi0 = hi; lo0 = lo;
        start = 1'b1; flush = 1'b1; op = 2'd3; src_a = 32'd1; src_b = 32'd1;
        #1;
        chk("flush_prio_stall", 64'(stall_req), 64'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_prio_busy", 64'(busy), 64'd0);
        chk("flush_prio_hilo", {hi, lo}, {hi0, lo0});

        // asynchronous reset in the middle of CALC
        start = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd5;
        #1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start = 1'b0;
        end
        #1;
        chk("midcalc_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("arst_stall", 64'(stall_req), 64'd0);
        chk("arst_busy",  64'(busy),      64'd0);
        chk("arst_done",  64'(done),      64'd0);
        chk("arst_hi",    64'(hi),        64'd0);
        chk("arst_lo",    64'(lo),        64'd0);
        tick();
        #2 rst = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) flag = 1'b1;
        end
        chk("arst_abandon", 64'(flag), 64'd0);
        run_op(2'd3, 32'd9, 32'd3, "divu_9_3");
        chk_hilo("divu_9_3", 32'd0, 32'd3);

        // randomized ops with biased corner operands
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = $urandom_range(0, 255);
                default: ;
            endcase
            run_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", n, ro));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
